// File: rtl/apu_pkg.sv
// apu_pkg: shared APU register addresses, read masks and frame-sequencer types
package apu_pkg;
  localparam logic [7:0] NR11 = 8'h11;
  localparam logic [7:0] NR14 = 8'h14;
  localparam logic [7:0] NR21 = 8'h16;
  localparam logic [7:0] NR24 = 8'h19;
  localparam logic [7:0] NR31 = 8'h1B;
  localparam logic [7:0] NR34 = 8'h1E;
  localparam logic [7:0] NR41 = 8'h20;
  localparam logic [7:0] NR44 = 8'h23;
  localparam int STEP_DIV_DEF = 8192;
  // Unimplemented register bits read back as 1
  localparam logic [7:0] NRX1_RD_MASK = 8'h3F;
  localparam logic [7:0] NRX4_RD_MASK = 8'hBF;
  typedef logic [2:0] step_t;
endpackage

// File: rtl/chan_len_ctrl_pulse_stretch.sv
// pulse_stretch: start strobe loads a PULSE_CYC down-counter, output high while nonzero
module pulse_stretch #(
  parameter int PULSE_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic start,
  output logic pulse
);
  logic [7:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (clr) r_cnt <= '0;
    else if (start) r_cnt <= 8'(PULSE_CYC);
    else if (r_cnt != '0) r_cnt <= r_cnt - 8'd1;
  assign pulse = |r_cnt;
endmodule

// File: rtl/chan_len_ctrl.sv
// chan_len_ctrl: NRx1/NRx4 decode and frame sequencer feeding one length counter.
// Optional EXTRA_LEN_CLK_EN adds the DMG extra length clock on enabling writes.
module chan_len_ctrl
  import apu_pkg::*;
#(
  parameter int          STEP_DIV  = STEP_DIV_DEF,
  parameter int          PULSE_CYC = 4,
  parameter logic [7:0]  NRX1_ADDR = NR11,
  parameter logic [7:0]  NRX4_ADDR = NR14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       apu_on,
  input  logic       wr_en,
  input  logic [7:0] addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic [5:0] len_load,
  output logic       len_enable,
  output logic       trigger,
  output logic       len_clk,
  output logic [2:0] step
);
  localparam int DW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  logic [DW-1:0] r_div;
  step_t         r_step;
  logic [1:0]    r_duty;
  logic [5:0]    r_len_load;
  logic          r_len_en;
  logic          w_wr1, w_wr4, w_wrap, w_extra, w_lc_start, w_trig_start;
  assign w_wr1 = wr_en && addr == NRX1_ADDR;
  assign w_wr4 = wr_en && addr == NRX4_ADDR;
  assign w_wrap = r_div == DW'(STEP_DIV - 1);
`ifdef EXTRA_LEN_CLK_EN
  // Enabling length while the coming step won't clock it costs one extra clock
  assign w_extra = w_wr4 && wr_data[6] && !r_len_en && !r_step[0] && !len_clk;
`else
  assign w_extra = 1'b0;
`endif
  // Wrapping out of an odd step lands on an even step: 256 Hz length clock
  assign w_lc_start = (w_wrap && r_step[0]) || w_extra;
  assign w_trig_start = w_wr4 && wr_data[7];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_div      <= '0;
      r_step     <= '0;
      r_duty     <= '0;
      r_len_load <= '0;
      r_len_en   <= 1'b0;
    end else if (!apu_on) begin
      r_div      <= '0;
      r_step     <= '0;
      r_duty     <= '0;
      r_len_load <= '0;
      r_len_en   <= 1'b0;
    end else begin
      r_div <= w_wrap ? '0 : r_div + DW'(1);
      if (w_wrap) r_step <= r_step + 3'd1;
      if (w_wr1) begin
        r_len_load <= wr_data[5:0];
        r_duty     <= wr_data[7:6];
      end
      if (w_wr4) r_len_en <= wr_data[6];
    end
  pulse_stretch #(.PULSE_CYC(PULSE_CYC)) u_trig (
    .clk(clk), .rst_n(rst_n), .clr(!apu_on), .start(w_trig_start), .pulse(trigger)
  );
  pulse_stretch #(.PULSE_CYC(PULSE_CYC)) u_len_clk (
    .clk(clk), .rst_n(rst_n), .clr(!apu_on), .start(w_lc_start), .pulse(len_clk)
  );
  assign rd_data = addr == NRX1_ADDR ? ({r_duty, 6'b0} | NRX1_RD_MASK)
                 : addr == NRX4_ADDR ? ({1'b0, r_len_en, 6'b0} | NRX4_RD_MASK)
                 : 8'hFF;
  assign len_load = r_len_load;
  assign len_enable = r_len_en;
  assign step = r_step;
endmodule

// File: tb/tb_chan_len_ctrl.sv
// tb_chan_len_ctrl: random and directed stimulus checked every cycle against
// an arithmetic model (step, pulses derived from edge counts since power-on).
module tb_chan_len_ctrl;
  import apu_pkg::*;
  localparam int SD = 8192;
  localparam int P  = 4;
  logic       clk = 1'b0, rst_n = 1'b0, apu_on = 1'b0, wr_en = 1'b0;
  logic [7:0] addr = 8'h00, wr_data = 8'h00;
  logic [7:0] rd_data;
  logic [5:0] len_load;
  logic       len_enable, trigger, len_clk;
  logic [2:0] step;
  chan_len_ctrl #(.STEP_DIV(SD), .PULSE_CYC(P), .NRX1_ADDR(NR11), .NRX4_ADDR(NR14)) dut (
    .clk(clk), .rst_n(rst_n), .apu_on(apu_on), .wr_en(wr_en), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .len_load(len_load), .len_enable(len_enable),
    .trigger(trigger), .len_clk(len_clk), .step(step)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  int n = 0, t_trig = -1000, e_lc = -1000;
  logic [5:0] m_load = '0;
  logic [1:0] m_duty = '0;
  logic       m_en = 1'b0;
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, n);
  endtask
  function automatic logic [2:0] f_step(input int k);
    return 3'((k / SD) % 8);
  endfunction
  function automatic logic f_lc(input int k);
    return (k >= 2 * SD && k % (2 * SD) < P) || (k - e_lc < P);
  endfunction
  function automatic logic [7:0] f_rd(input logic [7:0] a);
    return a == NR11 ? {m_duty, 6'h3F} : a == NR14 ? {1'b1, m_en, 6'h3F} : 8'hFF;
  endfunction
  task automatic cyc();
    int nb;
    logic [2:0] sb;
    logic ex;
    @(posedge clk);
    if (!rst_n || !apu_on) begin
      n = 0; t_trig = -1000; e_lc = -1000; m_load = '0; m_duty = '0; m_en = 1'b0;
    end else begin
      nb = n;
      sb = f_step(nb);
      ex = 1'b0;
      n++;
      if (wr_en && addr == NR11) begin
        m_load = wr_data[5:0];
        m_duty = wr_data[7:6];
      end
      if (wr_en && addr == NR14) begin
`ifdef EXTRA_LEN_CLK_EN
        ex = wr_data[6] && !m_en && !sb[0] && !f_lc(nb);
`endif
        if (ex) e_lc = n;
        m_en = wr_data[6];
        if (wr_data[7]) t_trig = n;
      end
    end
    #1;
    check("len_clk", 16'(len_clk), 16'(f_lc(n)));
    check("trigger", 16'(trigger), 16'(n - t_trig < P));
    check("step", 16'(step), 16'(f_step(n)));
    check("len_load", 16'(len_load), 16'(m_load));
    check("len_enable", 16'(len_enable), 16'(m_en));
    check("rd_data", 16'(rd_data), 16'(f_rd(addr)));
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    cyc();
    wr_en = 1'b0; addr = 8'h00;
  endtask
  initial begin
    int k, hc, ec, r;
    repeat (3) cyc();
    rst_n = 1'b1; apu_on = 1'b1;
    k = 0;
    while (!len_clk && k < 20000) begin cyc(); k++; end
    check("first_lc_edge", 16'(n), 16'(2 * SD));
    check("first_lc_step", 16'(step), 16'd2);
    while (n < 4 * SD + 5) cyc();
    wr(NR11, 8'hC5); addr = NR11; cyc();
    check("ll_c5", 16'(len_load), 16'h05); check("rd_c5", 16'(rd_data), 16'hFF);
    wr(NR11, 8'h47); addr = NR11; cyc();
    check("ll_47", 16'(len_load), 16'h07); check("rd_47", 16'(rd_data), 16'h7F);
    wr(NR14, 8'hC0);
    check("trig_c0", 16'(trigger), 16'd1); check("en_c0", 16'(len_enable), 16'd1);
    addr = NR14; cyc();
    check("rd_nr14", 16'(rd_data), 16'hFF);
    repeat (6) cyc();
    hc = 0;
    wr(NR14, 8'h80); hc += int'(trigger);
    cyc();           hc += int'(trigger);
    wr(NR14, 8'h80); hc += int'(trigger);
    repeat (8) begin cyc(); hc += int'(trigger); end
    check("retrig_len", 16'(hc), 16'd6);
    wr(NR14, 8'h80); cyc();
    apu_on = 1'b0; cyc();
    check("off_trig", 16'(trigger), 16'd0); check("off_step", 16'(step), 16'd0);
    check("off_lc", 16'(len_clk), 16'd0);
    wr(NR11, 8'h3F);
    check("off_ll", 16'(len_load), 16'd0);
    apu_on = 1'b1;
    repeat (3) cyc();
    ec = 0;
    wr(NR14, 8'h40); ec += int'(len_clk);
    repeat (6) begin cyc(); ec += int'(len_clk); end
`ifdef EXTRA_LEN_CLK_EN
    check("extra_step0", 16'(ec), 16'(P));
`else
    check("extra_step0", 16'(ec), 16'd0);
`endif
    wr(NR14, 8'h00);
    while (n < SD + 3) cyc();
    ec = 0;
    wr(NR14, 8'h40); ec += int'(len_clk);
    repeat (6) begin cyc(); ec += int'(len_clk); end
    check("extra_step1", 16'(ec), 16'd0);
    repeat (9000) begin
      r = $urandom_range(0, 15);
      if (r == 0) wr(NR11, 8'($urandom));
      else if (r == 1) wr(NR14, 8'($urandom));
      else begin
        r = $urandom_range(0, 2);
        addr = r == 0 ? NR11 : r == 1 ? NR14 : 8'($urandom);
        cyc();
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/chan_len_ctrl.md
Name: chan_len_ctrl

Overview:
- Register-side driver for one channel's length counter: decodes CPU writes to NRx1/NRx4 and produces the length counter's `len_load`, `trigger` and `len_enable` inputs.
- Contains the APU frame sequencer, which generates the 256 Hz `len_clk` that the length counter samples on its rising edge.
- Sits between the CPU bus decode and the per-channel length counter.

Parameters:
- STEP_DIV, 8192, `clk` cycles per frame-sequencer step (512 Hz at 4.194304 MHz).
- PULSE_CYC, 4, high time in `clk` cycles of each `trigger` and `len_clk` pulse; range 1..255, and must be < STEP_DIV.
- NRX1_ADDR, 8'h11, low address byte of the NRx1 register.
- NRX4_ADDR, 8'h14, low address byte of the NRx4 register.

Ports:
- clk  in  1  system clock, 4.194304 MHz
- rst_n  in  1  asynchronous active-low reset
- apu_on  in  1  NR52 bit 7; low holds the block cleared
- wr_en  in  1  one-cycle write strobe
- addr  in  8  register address, low byte
- wr_data  in  8  write data
- rd_data  out  8  combinational read data
- len_load  out  6  NRx1[5:0], to length counter
- len_enable  out  1  NRx4[6], to length counter
- trigger  out  1  trigger pulse, to length counter
- len_clk  out  1  length clock pulse, to length counter
- step  out  3  frame-sequencer step, for envelope/sweep consumers

Behaviour:
- Reset (rst_n=0, asynchronous) and apu_on=0 (synchronous) have the same effect:
  - all outputs 0, `duty`=0, prescaler=0, `step`=0;
  - writes ignored; rd_data still decodes.
- Prescaler:
  - counts 0..STEP_DIV-1 while apu_on=1;
  - on wrap, `step` <= `step`+1 mod 8.
- len_clk:
  - a pulse of PULSE_CYC cycles starts in the cycle the prescaler wraps into an even step (0, 2, 4, 6), giving a 256 Hz rising edge;
  - the first rising edge after apu_on 0->1 comes at the wrap into step 2, STEP_DIV*2 cycles later; step 0 emits no pulse at power-on.
- NRx1 write (wr_en && addr==NRX1_ADDR):
  - `len_load` <= wr_data[5:0] and `duty` <= wr_data[7:6] on the next edge.
- NRx4 write:
  - `len_enable` <= wr_data[6];
  - if wr_data[7]=1, `trigger` rises on the next edge and stays high PULSE_CYC cycles.
  - Retrigger while `trigger` is high reloads the pulse counter; no new edge is produced.
  - NRx4 written with trigger=1 and an NRx1 write in the same cycle is impossible, since there is one address per cycle.
  - An NRx1 write during an active trigger pulse updates `len_load` immediately.
- Reads (combinational), unused bits read 1:
  - addr==NRX1_ADDR -> {duty, 6'h3F};
  - addr==NRX4_ADDR -> {1'b1, len_enable, 6'h3F};
  - otherwise 8'hFF.
- A `len_clk` pulse and a `trigger` pulse may overlap. Both are driven as specified; arbitration is the length counter's job.
- apu_on falling mid-pulse: both pulses drop on the next edge.

Optional Feature:
- Macro: EXTRA_LEN_CLK_EN. It models the DMG quirk of an extra length clock.
- With the macro defined:
  - condition: an NRx4 write with wr_data[6]=1, while `len_enable` was 0 and `step`[0]==0 (the next step does not clock length), and no `len_clk` pulse active;
  - response: an extra PULSE_CYC-cycle `len_clk` pulse starts on the next edge;
  - if a regular pulse is active, no extra pulse is issued.
- Without the macro: `len_clk` comes only from the frame sequencer.

Decomposition:
- Shared package `apu_pkg`:
  - register address constants (NR11/NR14/NR21/...);
  - STEP_DIV default;
  - read-mask constants for NRx1/NRx4;
  - 3-bit step typedef.
- One natural sub-module, `pulse_stretch`:
  - a start strobe loads a PULSE_CYC down-counter; output is high while nonzero;
  - a restart while active reloads the counter;
  - instantiated twice: `trigger` and `len_clk`.

Test Plan:
- Power-on: rst_n low, then high, apu_on=1 -> all outputs 0; the first `len_clk` rising edge comes exactly 16384 cycles later with `step`=2; it is high 4 cycles; the next edge follows 16384 cycles later.
- Write NRx1 8'hC5 then read -> `len_load`=6'h05, rd_data=8'hFF; write NRx1 8'h47 then read -> `len_load`=6'h07, rd_data=8'h7F.
- Write NRx4 8'hC0 -> `len_enable`=1 and `trigger` high 4 cycles starting next edge; reading NRx4 returns 8'hFF.
- Write NRx4 8'h80 twice, 2 cycles apart -> `trigger` stays high continuously for 6 cycles, with one rising edge.
- apu_on dropped mid-trigger -> `trigger`, `len_clk` and `step` all 0 next cycle; a subsequent write 8'h3F to NRx1 leaves `len_load`=0.
- EXTRA_LEN_CLK_EN, `step`=0 after the pulse ends, `len_enable`=0: write NRx4 8'h40 -> extra 4-cycle `len_clk` pulse. Same write at `step`=1 -> no pulse. Without the macro -> no pulse in either case.
